// File: rtl/otter_muldiv.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, 34-cycle latency.
// Optional trivial-case fast path (latency 1) enabled by defining OTTER_MULDIV_FASTPATH_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 32 radix-2 iterations, one per cycle
// FIX   | sign correction and result selection
// DONE  | result valid, done pulse; may accept a back-to-back start
module otter_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  op_q;
    logic [63:0] acc;
    logic [31:0] opnd_b;
    logic [4:0]  cnt;
    logic        neg_res, neg_rem, div_zero;

    logic        a_signed, b_signed, a_neg, b_neg, accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_trial;
    logic [63:0] prod;
    logic [31:0] quo, remv, fix_res;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                 a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg  = a_signed & op_a[31];
    assign b_neg  = b_signed & op_b[31];
    assign a_mag  = a_neg ? (32'd0 - op_a) : op_a;
    assign b_mag  = b_neg ? (32'd0 - op_b) : op_b;
    assign accept = start & ~kill & ((state == IDLE) | (state == DONE));

`ifdef OTTER_MULDIV_FASTPATH_EN
    logic        fast_hit;
    logic [31:0] fast_res;
    always_comb begin
        fast_hit = 1'b0;
        fast_res = 32'd0;
        if (funct3[2]) begin
            if (op_b == 32'd0) begin
                fast_hit = 1'b1;
                fast_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
            end else if (!funct3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                fast_hit = 1'b1;
                fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
            end
        end else if (op_a == 32'd0 || op_b == 32'd0) begin
            fast_hit = 1'b1;
        end
    end
`else
    logic fast_hit;
    assign fast_hit = 1'b0;
`endif

    // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide
    assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd_b : 32'd0)};
    assign div_trial = {acc[63:32], acc[31]} - {1'b0, opnd_b};

    assign prod = neg_res ? (64'd0 - acc) : acc;
    assign quo  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    assign remv = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];

    always_comb begin
        case (op_q)
            3'b000:                 fix_res = prod[31:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[63:32];
            3'b100, 3'b101:         fix_res = div_zero ? 32'hFFFF_FFFF : quo;
            default:                fix_res = remv;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (fast_hit ? DONE : RUN) : IDLE;
            RUN:        if (cnt == 5'd31) state_next = FIX;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
        if (kill) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 3'd0;
            acc      <= 64'd0;
            opnd_b   <= 32'd0;
            cnt      <= 5'd0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            result   <= 32'd0;
        end else if (accept) begin
            op_q     <= funct3;
            acc      <= {32'd0, a_mag};
            opnd_b   <= b_mag;
            cnt      <= 5'd0;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= funct3[2] & (op_b == 32'd0);
`ifdef OTTER_MULDIV_FASTPATH_EN
            if (fast_hit) result <= fast_res;
`endif
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            if (op_q[2]) begin
                if (!div_trial[32]) acc <= {div_trial[31:0], acc[30:0], 1'b1};
                else                acc <= {acc[62:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[31:1]};
            end
        end else if (state == FIX && !kill) begin
            result <= fix_res;
        end
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);
endmodule

// File: tb/tb_otter_muldiv.sv
// Self-checking bench for otter_muldiv: directed vectors, corner sequences and random ops vs. an arithmetic model.
module tb_otter_muldiv;
    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    otter_muldiv dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .kill(kill), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] pu;
        int          sa, sb;
        sa = a;
        sb = b;
        pu = {32'd0, a} * {32'd0, b};
        case (f)
            3'b000: return pu[31:0];
            3'b001: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'b010: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            3'b011: return pu[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic trivial;
        if (f[2]) trivial = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else      trivial = (a == 0) || (b == 0);
`ifdef OTTER_MULDIV_FASTPATH_EN
        return trivial ? 1 : 34;
`else
        return trivial ? 34 : 34;
`endif
    endfunction

    // Called at a negedge with the unit idle or in DONE; returns at the negedge where done is seen.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bsy);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        lat = 0; bsy = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (busy) bsy++;
            if (done) break;
        end
        res = result;
        if (!done) begin
            total++; bad++;
            $display("FAIL op_timeout actual=no_done required=done f=%0d", f);
        end
    endtask

    task automatic watch_no_done(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    initial begin
        logic [31:0] res, exp, prior;
        logic [2:0]  f;
        logic [31:0] a, b;
        int          lat, bsy, seen, el;

        vecs[0] = '{3'b000, 32'd20,         32'hFFFF_FFF6, 32'hFFFF_FF38};
        vecs[1] = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2] = '{3'b001, 32'hFFFF_FFF6,  32'd20,        32'hFFFF_FFFF};
        vecs[3] = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{3'b100, 32'd50,         32'd0,         32'hFFFF_FFFF};
        vecs[5] = '{3'b111, 32'd50,         32'd0,         32'd50};
        vecs[6] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[8] = '{3'b110, 32'hFFFF_FFCE,  32'd0,         32'hFFFF_FFCE};
        vecs[9] = '{3'b000, 32'd0,          32'h1234_5678, 32'd0};

        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);

        foreach (vecs[i]) begin
            el = exp_latency(vecs[i].f, vecs[i].a, vecs[i].b);
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bsy);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, el);
            check($sformatf("vec%0d_busy_cycles", i), bsy, (el == 34) ? 33 : 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_result_hold", i), result, vecs[i].exp);
        end

        // back-to-back issue on done cycles
        do_op(3'b100, 32'hFFFF_FFCE, 32'd3, res, lat, bsy);
        check("b2b_div", res, 32'hFFFF_FFF0);
        do_op(3'b110, 32'hFFFF_FFCE, 32'd3, res, lat, bsy);
        check("b2b_rem", res, 32'hFFFF_FFFE);
        check("b2b_rem_latency", lat, 34);
        do_op(3'b101, 32'd50, 32'd3, res, lat, bsy);
        check("b2b_divu", res, 32'd16);
        check("b2b_divu_latency", lat, 34);
        @(negedge clk);
        check("b2b_done_pulse", {31'd0, done}, 32'd0);

        // kill during RUN cycle 10
        prior = result;
        funct3 = 3'b000; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_done", {31'd0, done}, 32'd0);
        check("kill_result", result, prior);
        watch_no_done(40, seen);
        check("kill_no_done", seen, 0);
        check("kill_result_after", result, prior);
        do_op(3'b000, 32'd7, 32'd9, res, lat, bsy);
        check("after_kill_result", res, 32'd63);
        check("after_kill_latency", lat, 34);
        @(negedge clk);

        // kill and start together: start ignored
        funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", {31'd0, busy}, 32'd0);
        check("kill_start_done", {31'd0, done}, 32'd0);

        // start while busy is ignored
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 5) begin
                start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        check("busy_start_result", result, 32'd15);
        check("busy_start_latency", lat, 34);
        @(negedge clk);

        // rst mid-RUN
        funct3 = 3'b000; op_a = 32'h1234; op_b = 32'h55; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        watch_no_done(40, seen);
        check("rst_no_done", seen, 0);
        do_op(3'b000, 32'd6, 32'd7, res, lat, bsy);
        check("after_rst_result", res, 32'd42);

        // random operations against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = ref_model(f, a, b);
            el = exp_latency(f, a, b);
            do_op(f, a, b, res, lat, bsy);
            check($sformatf("rand%0d_f%0d_a%h_b%h", i, f, a, b), res, exp);
            check($sformatf("rand%0d_latency", i), lat, el);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
